// File: rtl/lb_pkg.sv
// lb_pkg: shared helpers for the lb_fifo line buffer and its SRAM macro model.
package lb_pkg;

   // Occupancy of the two-entry prefetch stage (0, 1 or 2 entries).
   typedef logic [1:0] pf_cnt_t;

   function automatic int lb_addr_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/lb_sram_1r1w.sv
// lb_sram_1r1w: behavioural 1R1W SRAM, one-cycle registered read, swappable for a hard macro.
module lb_sram_1r1w
   import lb_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int DEPTH  = 32,
   parameter int ADDR_W = lb_addr_w(DEPTH)
) (
   input  logic              R0_clk,
   input  logic              R0_en,
   input  logic [ADDR_W-1:0] R0_addr,
   output logic [WIDTH-1:0]  R0_data,
   input  logic              W0_clk,
   input  logic              W0_en,
   input  logic [ADDR_W-1:0] W0_addr,
   input  logic [WIDTH-1:0]  W0_data
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge W0_clk) begin
      if (W0_en) mem[W0_addr] <= W0_data;
   end

   // Read data holds between reads, like most compiled macros.
   always_ff @(posedge R0_clk) begin
      if (R0_en) R0_data <= mem[R0_addr];
   end

endmodule

// File: rtl/lb_fifo.sv
// lb_fifo: line-buffer FIFO over a 1-cycle-latency SRAM with a two-entry show-ahead prefetch.
module lb_fifo
   import lb_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int DEPTH    = 32,
   parameter int AF_LEVEL = DEPTH - 4,
   parameter int ADDR_W   = lb_addr_w(DEPTH)
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WIDTH-1:0]  in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [WIDTH-1:0]  out_data,
   output logic [ADDR_W:0]   count,
   output logic              almost_full
);

   localparam logic [ADDR_W:0]   FULL_LVL = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0]   AF_LVL   = (ADDR_W+1)'(AF_LEVEL);
   localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
   localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

   logic [ADDR_W-1:0] wr_ptr, rd_ptr;
   logic [ADDR_W:0]   mem_cnt, count_n;
   pf_cnt_t           pf_cnt, pf_occ, pf_cnt_n, pf_slot;
   logic              in_flight;
   logic [WIDTH-1:0]  head_q, next_q, rd_data;
   logic              push, pop, rd_issue;

   // Handshake: a beat transfers on a rising edge where valid & ready are both high.
   // Valid never waits on ready; in_ready is a pure register, so out_ready has no
   // combinational path to it. out_data is the head entry while out_valid is high.
   assign push      = in_valid & in_ready & ~flush;
   assign pop       = out_valid & out_ready;
   assign out_valid = (pf_cnt != 2'd0);
   assign out_data  = head_q;

   // A read may be issued into the slot that this cycle's pop frees, which keeps
   // one read in flight every cycle during a sustained stream.
   assign pf_occ   = pf_cnt + pf_cnt_t'(in_flight);
   assign rd_issue = ~flush && (mem_cnt != '0) &&
                     ((pf_occ < 2'd2) || (pop && (pf_occ == 2'd2)));
   assign pf_slot  = pf_cnt - pf_cnt_t'(pop);
   assign pf_cnt_n = pf_slot + pf_cnt_t'(in_flight);

   always_comb begin
      count_n = count;
      if (push && !pop)      count_n = count + CNT_ONE;
      else if (!push && pop) count_n = count - CNT_ONE;
   end

   always_ff @(posedge clock) begin
      if (!reset_n || flush) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         mem_cnt     <= '0;
         count       <= '0;
         pf_cnt      <= '0;
         in_flight   <= 1'b0;
         head_q      <= '0;
         next_q      <= '0;
         almost_full <= 1'b0;
         in_ready    <= reset_n;
      end else begin
         if (push)     wr_ptr <= wr_ptr + PTR_ONE;
         if (rd_issue) rd_ptr <= rd_ptr + PTR_ONE;

         case ({push, rd_issue})
            2'b10:   mem_cnt <= mem_cnt + CNT_ONE;
            2'b01:   mem_cnt <= mem_cnt - CNT_ONE;
            default: mem_cnt <= mem_cnt;
         endcase

         count       <= count_n;
         in_ready    <= (count_n < FULL_LVL);
         almost_full <= (count_n >= AF_LVL);

         in_flight <= rd_issue;
         pf_cnt    <= pf_cnt_n;

         // Popping a full stage shifts next into head; returning read data lands
         // in whichever slot is first free after the pop.
         if (pop && (pf_cnt == 2'd2)) head_q <= next_q;
         if (in_flight) begin
            if (pf_slot == 2'd0) head_q <= rd_data;
            else                 next_q <= rd_data;
         end
      end
   end

   lb_sram_1r1w #(
      .WIDTH  (WIDTH),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_sram (
      .R0_clk  (clock),
      .R0_en   (rd_issue),
      .R0_addr (rd_ptr),
      .R0_data (rd_data),
      .W0_clk  (clock),
      .W0_en   (push),
      .W0_addr (wr_ptr),
      .W0_data (in_data)
   );

endmodule

// File: tb/tb_lb_fifo.sv
// tb_lb_fifo: directed vector table plus model-checked sequences for lb_fifo (WIDTH=8, DEPTH=32).
`timescale 1ns/1ps
module tb_lb_fifo;

   localparam int WIDTH    = 8;
   localparam int DEPTH    = 32;
   localparam int AF_LEVEL = DEPTH - 4;
   localparam int ADDR_W   = 5;
   localparam int N_VEC    = 18;

   // ---------------- clock / reset / DUT ----------------
   logic              clock = 1'b0;
   logic              reset_n, flush, in_valid, in_ready;
   logic              out_valid, out_ready, almost_full;
   logic [WIDTH-1:0]  in_data, out_data;
   logic [ADDR_W:0]   count;

   always #5 clock = ~clock;

   lb_fifo #(
      .WIDTH    (WIDTH),
      .DEPTH    (DEPTH),
      .AF_LEVEL (AF_LEVEL)
   ) dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .flush       (flush),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_data     (in_data),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .count       (count),
      .almost_full (almost_full)
   );

   // ---------------- scoreboard / reference model ----------------
   int               n_tests = 0;
   int               n_fail  = 0;
   int               cyc     = 0;
   logic [WIDTH-1:0] exp_q[$];
   int               t_q[$];
   logic             mdl_rdy  = 1'b0;
   logic [WIDTH-1:0] mdl_last = '0;
   logic             got_pop;
   logic [WIDTH-1:0] pop_data;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: cycle %0d got 0x%0h expected 0x%0h", name, cyc, act, exp);
      end
   endtask

   // An entry written at edge k is visible as the head from edge k+2 onwards.
   function automatic logic mdl_valid();
      return (exp_q.size() > 0) && (t_q[0] + 2 <= cyc);
   endfunction

   // ---------------- driver: one clock cycle ----------------
   task automatic step(input logic iv, input logic [WIDTH-1:0] d, input logic ordy,
                       input logic fl, input logic rst);
      logic             do_push, do_pop;
      logic [WIDTH-1:0] exp_data;
      reset_n   = ~rst;
      flush     = fl;
      in_valid  = iv;
      in_data   = d;
      out_ready = ordy;
      do_push   = iv && mdl_rdy && !fl && !rst;
      do_pop    = ordy && mdl_valid() && !fl && !rst;
      got_pop   = do_pop;
      if (do_pop) pop_data = out_data;
      @(posedge clock);
      cyc++;
      if (rst || fl) begin
         exp_q.delete();
         t_q.delete();
         mdl_last = '0;
      end else begin
         if (do_pop) begin
            mdl_last = exp_q.pop_front();
            void'(t_q.pop_front());
         end
         if (do_push) begin
            exp_q.push_back(d);
            t_q.push_back(cyc);
         end
      end
      mdl_rdy = !rst && (exp_q.size() < DEPTH);
      #1;
      exp_data = mdl_last;
      if (mdl_valid()) exp_data = exp_q[0];
      check("in_ready", 32'(in_ready), 32'(mdl_rdy));
      check("count", 32'(count), 32'(exp_q.size()));
      check("almost_full", 32'(almost_full), 32'(exp_q.size() >= AF_LEVEL));
      check("out_valid", 32'(out_valid), 32'(mdl_valid()));
      check("out_data", 32'(out_data), 32'(exp_data));
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic             rst, fl, iv, ordy;
      logic [WIDTH-1:0] d;
      logic             ov;
      logic [WIDTH-1:0] od;
      int               cnt;
      logic             rdy;
   } vec_t;

   vec_t vecs[N_VEC];

   function automatic vec_t mk(input logic rst, input logic fl, input logic iv,
                               input logic ordy, input logic [WIDTH-1:0] d,
                               input logic ov, input logic [WIDTH-1:0] od,
                               input int cnt, input logic rdy);
      vec_t v;
      v.rst = rst; v.fl = fl; v.iv = iv; v.ordy = ordy; v.d = d;
      v.ov = ov; v.od = od; v.cnt = cnt; v.rdy = rdy;
      return v;
   endfunction

   initial begin : timeout
      #1_000_000;
      $display("FAIL timeout: simulation exceeded its time budget");
      $fatal(1, "timeout");
   end

   initial begin : main
      logic             seen;
      logic [WIDTH-1:0] first_pop, rd;
      logic             riv, rord;
      int               npop;

      //          rst fl iv ordy d      ov od     cnt rdy
      vecs[0]  = mk(1, 0, 0, 0, 8'h00, 0, 8'h00, 0, 0);
      vecs[1]  = mk(1, 0, 1, 0, 8'hFF, 0, 8'h00, 0, 0);
      vecs[2]  = mk(0, 0, 0, 0, 8'h00, 0, 8'h00, 0, 1);
      vecs[3]  = mk(0, 0, 1, 0, 8'h01, 0, 8'h00, 1, 1);
      vecs[4]  = mk(0, 0, 1, 0, 8'h02, 0, 8'h00, 2, 1);
      vecs[5]  = mk(0, 0, 1, 0, 8'h03, 1, 8'h01, 3, 1);
      vecs[6]  = mk(0, 0, 1, 0, 8'h04, 1, 8'h01, 4, 1);
      vecs[7]  = mk(0, 0, 1, 0, 8'h05, 1, 8'h01, 5, 1);
      vecs[8]  = mk(0, 0, 0, 0, 8'h00, 1, 8'h01, 5, 1);
      vecs[9]  = mk(0, 0, 0, 1, 8'h00, 1, 8'h02, 4, 1);
      vecs[10] = mk(0, 0, 0, 1, 8'h00, 1, 8'h03, 3, 1);
      vecs[11] = mk(0, 0, 0, 1, 8'h00, 1, 8'h04, 2, 1);
      vecs[12] = mk(0, 0, 0, 1, 8'h00, 1, 8'h05, 1, 1);
      vecs[13] = mk(0, 0, 0, 1, 8'h00, 0, 8'h05, 0, 1);
      vecs[14] = mk(0, 0, 1, 1, 8'hAA, 0, 8'h05, 1, 1);
      vecs[15] = mk(0, 0, 0, 1, 8'h00, 0, 8'h05, 1, 1);
      vecs[16] = mk(0, 0, 0, 0, 8'h00, 1, 8'hAA, 1, 1);
      vecs[17] = mk(0, 1, 0, 0, 8'h00, 0, 8'h00, 0, 1);

      for (int i = 0; i < N_VEC; i++) begin
         step(vecs[i].iv, vecs[i].d, vecs[i].ordy, vecs[i].fl, vecs[i].rst);
         check($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].ov));
         check($sformatf("vec%0d_out_data", i), 32'(out_data), 32'(vecs[i].od));
         check($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].cnt));
         check($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].rdy));
      end

      // Fill to DEPTH with no pops, then one pop reopens in_ready.
      step(0, 8'h00, 0, 1, 0);
      for (int i = 0; i < DEPTH; i++) begin
         step(1, WIDTH'(8'h40 + i), 0, 0, 0);
         if (i == AF_LEVEL - 2) check("fill_af_below", 32'(almost_full), 32'(0));
         if (i == AF_LEVEL - 1) check("fill_af_at_level", 32'(almost_full), 32'(1));
      end
      check("full_in_ready", 32'(in_ready), 32'(0));
      check("full_count", 32'(count), 32'(DEPTH));
      step(1, 8'hEE, 0, 0, 0);
      check("full_drop_count", 32'(count), 32'(DEPTH));
      step(0, 8'h00, 1, 0, 0);
      check("after_pop_in_ready", 32'(in_ready), 32'(1));
      for (int i = 0; i < DEPTH + 4; i++) step(0, 8'h00, 1, 0, 0);
      check("drain_empty", 32'(count), 32'(0));

      // Sustained push+pop with four entries queued: no bubbles, constant count.
      step(0, 8'h00, 0, 1, 0);
      for (int i = 0; i < 4; i++) step(1, WIDTH'(8'h10 + i), 0, 0, 0);
      for (int i = 0; i < 3; i++) step(0, 8'h00, 0, 0, 0);
      for (int i = 0; i < 200; i++) begin
         rd = WIDTH'($urandom_range(0, 255));
         step(1, rd, 1, 0, 0);
         check("stream_no_bubble", 32'(out_valid), 32'(1));
         check("stream_count", 32'(count), 32'(4));
      end

      // Random 50% valid/ready traffic; pointers wrap many times.
      step(0, 8'h00, 0, 1, 0);
      for (int i = 0; i < 3000; i++) begin
         riv  = 1'($urandom_range(0, 1));
         rord = 1'($urandom_range(0, 1));
         rd   = WIDTH'($urandom_range(0, 255));
         step(riv, rd, rord, 0, 0);
      end
      for (int i = 0; i < DEPTH + 4; i++) step(0, 8'h00, 1, 0, 0);
      check("random_drained", 32'(count), 32'(0));

      // Flush with 10 entries queued and a read in flight; push in flush cycle is lost.
      step(0, 8'h00, 0, 1, 0);
      for (int i = 0; i < 11; i++) step(1, WIDTH'(8'h60 + i), 0, 0, 0);
      for (int i = 0; i < 3; i++) step(0, 8'h00, 0, 0, 0);
      step(0, 8'h00, 1, 0, 0);
      check("preflush_count", 32'(count), 32'(10));
      step(1, 8'h55, 0, 1, 0);
      check("flush_out_valid", 32'(out_valid), 32'(0));
      check("flush_count", 32'(count), 32'(0));
      check("flush_out_data", 32'(out_data), 32'(0));
      step(1, 8'hAA, 1, 0, 0);
      seen = 1'b0;
      first_pop = '0;
      for (int i = 0; i < 6; i++) begin
         step(0, 8'h00, 1, 0, 0);
         if (got_pop && !seen) begin
            seen = 1'b1;
            first_pop = pop_data;
         end
      end
      check("flush_first_pop_seen", 32'(seen), 32'(1));
      check("flush_first_pop_data", 32'(first_pop), 32'(8'hAA));
      check("flush_then_empty", 32'(count), 32'(0));

      // One-cycle reset mid-stream; no stale data may emerge afterwards.
      for (int i = 0; i < 6; i++) step(1, WIDTH'(8'h80 + i), 0, 0, 0);
      for (int i = 0; i < 3; i++) step(0, 8'h00, 0, 0, 0);
      step(1, 8'h90, 1, 0, 0);
      step(1, 8'h91, 1, 0, 0);
      step(1, 8'h77, 1, 0, 1);
      check("rst_in_ready", 32'(in_ready), 32'(0));
      check("rst_out_valid", 32'(out_valid), 32'(0));
      check("rst_count", 32'(count), 32'(0));
      check("rst_out_data", 32'(out_data), 32'(0));
      check("rst_almost_full", 32'(almost_full), 32'(0));
      step(0, 8'h00, 0, 0, 0);
      check("rst_release_in_ready", 32'(in_ready), 32'(1));
      for (int i = 0; i < 3; i++) step(1, WIDTH'(8'hC0 + i), 0, 0, 0);
      npop = 0;
      seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
         step(0, 8'h00, 1, 0, 0);
         if (got_pop) begin
            if (!seen) first_pop = pop_data;
            seen = 1'b1;
            npop++;
         end
      end
      check("rst_pop_total", 32'(npop), 32'(3));
      check("rst_first_pop", 32'(first_pop), 32'(8'hC0));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
